// File: rtl/sisc_ctrl.sv
// sisc_ctrl -- multi-cycle control unit for the SISC processor.
//
// Walks every instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
// It also holds the processor status register {C,V,N,Z}, which is loaded from
// the ALU at the end of EXECUTE. It evaluates conditional branches in DECODE
// against that latched status.
//
// Ports:
//   clk       system clock
//   rst_f     asynchronous active-low reset
//   opcode    ir[31:28], stable from DECODE through WRITEBACK
//   mm        ir[27:24], branch condition mask {C,V,N,Z}
//   stat      ALU status {C,V,N,Z} (combinational from the ALU)
//   stat_en   ALU request to save its status
//   alu_op    ALU control: bit1 = non-arith (no status save), bit0 = immediate
//   pc_rst    clear PC
//   pc_write  PC load enable
//   pc_sel    0 = PC+1, 1 = branch target
//   br_sel    0 = absolute target, 1 = PC-relative target
//   ir_load   IR load enable
//   rb_sel    register-file read port B addresses Rd (store data)
//   mm_sel    memory address taken from the ALU result
//   dm_we     data-memory write enable
//   wb_sel    register writeback comes from memory
//   rf_we     register-file write enable
//   halted    processor halted
//   stat_q    current status register
//
// All outputs are a combinational decode of the state and the opcode. In
// DECODE they also depend on mm and stat_q. The reset value of the state
// register is START0. This means the reset-time outputs (pc_rst=1,
// alu_op=2'b10) appear as soon as rst_f falls.

module sisc_ctrl #(
    parameter logic [3:0] STAT_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    input  logic       stat_en,
    output logic [1:0] alu_op,
    output logic       pc_rst,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       br_sel,
    output logic       ir_load,
    output logic       rb_sel,
    output logic       mm_sel,
    output logic       dm_we,
    output logic       wb_sel,
    output logic       rf_we,
    output logic       halted,
    output logic [3:0] stat_q
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_ALU_REG = 4'h1;
    localparam logic [3:0] OP_ALU_IMM = 4'h2;
    localparam logic [3:0] OP_BRA     = 4'h4;
    localparam logic [3:0] OP_BRR     = 4'h5;
    localparam logic [3:0] OP_BNE     = 4'h6;
    localparam logic [3:0] OP_BNR     = 4'h7;
    localparam logic [3:0] OP_LOD     = 4'h8;
    localparam logic [3:0] OP_STR     = 4'h9;
    localparam logic [3:0] OP_HLT     = 4'hF;

    // ALU control encodings
    localparam logic [1:0] ALU_REG  = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;  // non-arith, never saves status
    localparam logic [1:0] ALU_ADDR = 2'b11;  // immediate address calculation

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] stat_reg;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic is_alu_reg;
    logic is_alu_imm;
    logic is_alu;
    logic is_lod;
    logic is_str;
    logic is_mem_op;
    logic is_hlt;
    logic is_br_if;      // branch taken when the condition hits
    logic is_br_ifnot;   // branch taken when the condition misses
    logic is_br_rel;     // target is PC-relative

    assign is_alu_reg  = (opcode == OP_ALU_REG);
    assign is_alu_imm  = (opcode == OP_ALU_IMM);
    assign is_alu      = is_alu_reg | is_alu_imm;
    assign is_lod      = (opcode == OP_LOD);
    assign is_str      = (opcode == OP_STR);
    assign is_mem_op   = is_lod | is_str;
    assign is_hlt      = (opcode == OP_HLT);
    assign is_br_if    = (opcode == OP_BRA) | (opcode == OP_BRR);
    assign is_br_ifnot = (opcode == OP_BNE) | (opcode == OP_BNR);
    assign is_br_rel   = (opcode == OP_BRR) | (opcode == OP_BNR);

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    // A zero mask means "always". That makes BRA/BRR unconditional, and
    // it makes the inverted forms BNE/BNR never taken.
    logic [3:0] cond_bits;
    logic       cond_hit;
    logic       br_taken;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cond
            assign cond_bits[gi] = mm[gi] & stat_reg[gi];
        end
    endgenerate

    assign cond_hit = (mm == 4'b0000) | (|cond_bits);
    assign br_taken = (is_br_if & cond_hit) | (is_br_ifnot & ~cond_hit);

    // alu_op value held through EXECUTE, MEM and WRITEBACK
    logic [1:0] alu_op_active;

    always_comb begin
        alu_op_active = ALU_PASS;
        if (is_alu_reg) begin
            alu_op_active = ALU_REG;
        end else if (is_alu_imm) begin
            alu_op_active = ALU_IMM;
        end else if (is_mem_op) begin
            alu_op_active = ALU_ADDR;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_reg <= START0;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            START0:    state_next = START1;
            START1:    state_next = FETCH;
            FETCH:     state_next = DECODE;
            DECODE:    state_next = is_hlt ? HALT : EXECUTE;
            EXECUTE:   state_next = MEM;
            MEM:       state_next = WRITEBACK;
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = START0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        alu_op   = ALU_PASS;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        rb_sel   = 1'b0;
        mm_sel   = 1'b0;
        dm_we    = 1'b0;
        wb_sel   = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;

        unique case (state_reg)
            START0: begin
                pc_rst = 1'b1;
            end
            START1: begin
            end
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end
            DECODE: begin
                // The PC was already incremented in FETCH, so a relative
                // target is formed from PC+1.
                if (br_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_br_rel;
                end
            end
            EXECUTE: begin
                alu_op = alu_op_active;
            end
            MEM: begin
                alu_op = alu_op_active;
                if (is_mem_op) begin
                    mm_sel = 1'b1;
                end
                if (is_str) begin
                    rb_sel = 1'b1;
                    dm_we  = 1'b1;
                end
            end
            WRITEBACK: begin
                alu_op = alu_op_active;
                if (is_alu) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b0;
                end
                if (is_lod) begin
                    rf_we  = 1'b1;
                    wb_sel = 1'b1;
                    mm_sel = 1'b1;
                end
                if (is_str) begin
                    // Keep address and data selects stable for one more
                    // cycle, but do not write again.
                    rb_sel = 1'b1;
                    mm_sel = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status register
    // ------------------------------------------------------------------
    // Only ALU register/immediate ops may update the status, and only on the
    // edge that ends EXECUTE. A stat_en seen in any other state or with any
    // other opcode is ignored.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            stat_reg <= STAT_RESET;
        end else if ((state_reg == EXECUTE) && stat_en && is_alu) begin
            stat_reg <= stat;
        end
    end

    assign stat_q = stat_reg;

endmodule

// File: tb/tb_sisc_ctrl.sv
// Testbench for sisc_ctrl. It uses directed scenarios followed by random
// instructions, all checked against a reference model inside the bench.
// Output vector order in comparisons:
// {alu_op[1:0], pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel, mm_sel,
//  dm_we, wb_sel, rf_we, halted}

module tb_sisc_ctrl;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       stat_en;
    logic [1:0] alu_op;
    logic       pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel;
    logic       mm_sel, dm_we, wb_sel, rf_we, halted;
    logic [3:0] stat_q;

    sisc_ctrl #(.STAT_RESET(4'b0000)) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .stat_en  (stat_en),
        .alu_op   (alu_op),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .ir_load  (ir_load),
        .rb_sel   (rb_sel),
        .mm_sel   (mm_sel),
        .dm_we    (dm_we),
        .wb_sel   (wb_sel),
        .rf_we    (rf_we),
        .halted   (halted),
        .stat_q   (stat_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] sq_model;   // model of the status register

    // Model phases
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEM = 3, PH_WB = 4;
    localparam int PH_RESET = 10, PH_START1 = 11, PH_HALT = 12;

    function automatic logic [12:0] obs_vec();
        return {alu_op, pc_rst, pc_write, pc_sel, br_sel, ir_load, rb_sel,
                mm_sel, dm_we, wb_sel, rf_we, halted};
    endfunction

    // Expected controls for one cycle, derived from the instruction's meaning
    function automatic logic [12:0] exp_vec(int ph, logic [3:0] op, logic [3:0] m,
                                            logic [3:0] sq);
        logic [1:0] a;
        logic prst, pw, ps, bs, il, rb, ms, dw, ws, rw, h;
        bit hit, taken;
        a = 2'b10;
        {prst, pw, ps, bs, il, rb, ms, dw, ws, rw, h} = '0;
        case (ph)
            PH_RESET: prst = 1'b1;
            PH_FETCH: begin il = 1'b1; pw = 1'b1; end
            PH_DECODE: begin
                hit   = (m == 4'd0) || ((m & sq) != 4'd0);
                taken = ((op == 4'h4 || op == 4'h5) && hit) ||
                        ((op == 4'h6 || op == 4'h7) && !hit);
                if (taken) begin
                    pw = 1'b1;
                    ps = 1'b1;
                    bs = (op == 4'h5 || op == 4'h7);
                end
            end
            PH_EXEC, PH_MEM, PH_WB: begin
                if (op == 4'h1) a = 2'b00;
                else if (op == 4'h2) a = 2'b01;
                else if (op == 4'h8 || op == 4'h9) a = 2'b11;
                if (ph == PH_MEM && op == 4'h8) ms = 1'b1;
                if (ph == PH_MEM && op == 4'h9) begin ms = 1'b1; rb = 1'b1; dw = 1'b1; end
                if (ph == PH_WB && (op == 4'h1 || op == 4'h2)) rw = 1'b1;
                if (ph == PH_WB && op == 4'h8) begin rw = 1'b1; ws = 1'b1; ms = 1'b1; end
                if (ph == PH_WB && op == 4'h9) begin rb = 1'b1; ms = 1'b1; end
            end
            PH_HALT: h = 1'b1;
            default: ;
        endcase
        return {a, prst, pw, ps, bs, il, rb, ms, dw, ws, rw, h};
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_cycle(input string tag, input int ph, input logic [3:0] op,
                             input logic [3:0] m);
        chk({tag, "_ctl"}, obs_vec(), exp_vec(ph, op, m, sq_model));
        chk({tag, "_stat"}, {9'd0, stat_q}, {9'd0, sq_model});
    endtask

    // Advance one clock, then drive inputs 1 time unit after the edge and
    // leave 1 more unit for the combinational outputs to settle.
    task automatic step(input logic [3:0] op, input logic [3:0] m,
                        input logic [3:0] st, input logic en);
        @(posedge clk);
        #1;
        opcode  = op;
        mm      = m;
        stat    = st;
        stat_en = en;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_f = 1'b0;
        #1;
        sq_model = 4'b0000;
        chk_cycle("reset_async", PH_RESET, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            chk_cycle("reset_hold", PH_RESET, 4'h0, 4'h0);
        end
        @(posedge clk);
        #1 rst_f = 1'b1;
        #1;
        chk_cycle("start0", PH_RESET, 4'h0, 4'h0);
        step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        chk_cycle("start1", PH_START1, 4'h0, 4'h0);
    endtask

    // Run one instruction through phases 0..last_ph. When fix=1, the EXECUTE
    // cycle uses the given stat/stat_en. Otherwise those inputs are random.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input bit fix,
                             input logic [3:0] fst, input logic fen, input int last_ph);
        logic [3:0] st;
        logic       en;
        int         lim;
        lim = (op == 4'hF) ? PH_DECODE : last_ph;
        $display("instr op=%h mm=%b stat_q_model=%b", op, m, sq_model);
        for (int ph = 0; ph <= lim; ph++) begin
            st = 4'($urandom);
            en = 1'($urandom);
            if (fix && ph == PH_EXEC) begin
                st = fst;
                en = fen;
            end
            // The opcode is arbitrary during FETCH because the IR is not loaded yet.
            step((ph == PH_FETCH) ? 4'($urandom) : op, m, st, en);
            chk_cycle($sformatf("op%h_ph%0d", op, ph), ph, op, m);
            if (ph == PH_EXEC && en && (op == 4'h1 || op == 4'h2)) sq_model = st;
        end
    endtask

    initial begin
        rst_f   = 1'b0;
        opcode  = 4'h0;
        mm      = 4'h0;
        stat    = 4'h0;
        stat_en = 1'b0;
        sq_model = 4'b0000;

        do_reset();

        // Back-to-back NOOPs: ir_load every 5 clocks
        run_instr(4'h0, 4'h0, 0, 4'h0, 1'b0, PH_WB);
        run_instr(4'h0, 4'h0, 0, 4'h0, 1'b0, PH_WB);

        // ALU register op that saves its status
        run_instr(4'h1, 4'h0, 1, 4'b0011, 1'b1, PH_WB);
        // Immediate add sets status to Z only
        run_instr(4'h2, 4'h0, 1, 4'b0001, 1'b1, PH_WB);
        // BRA: hit, then miss
        run_instr(4'h4, 4'b0001, 0, 4'h0, 1'b0, PH_WB);
        run_instr(4'h4, 4'b0100, 0, 4'h0, 1'b0, PH_WB);
        // BNR taken (relative), BRR unconditional, BNE with mm=0 never taken
        run_instr(4'h7, 4'b0010, 0, 4'h0, 1'b0, PH_WB);
        run_instr(4'h5, 4'b0000, 0, 4'h0, 1'b0, PH_WB);
        run_instr(4'h6, 4'b0000, 0, 4'h0, 1'b0, PH_WB);
        // LOD ignores stat_en
        run_instr(4'h8, 4'h0, 1, 4'b1111, 1'b1, PH_WB);
        // STR
        run_instr(4'h9, 4'h0, 1, 4'b1110, 1'b1, PH_WB);
        // ALU op with stat_en low keeps status
        run_instr(4'h1, 4'h0, 1, 4'b1000, 1'b0, PH_WB);
        // Unused opcodes behave as NOOP
        run_instr(4'hB, 4'h0, 1, 4'b1000, 1'b1, PH_WB);

        // Random instruction stream (no HLT)
        for (int k = 0; k < 60; k++) begin
            run_instr(4'($urandom_range(0, 14)), 4'($urandom), 0, 4'h0, 1'b0, PH_WB);
        end

        // HLT, then HALT is held for 20 clocks
        run_instr(4'hF, 4'($urandom), 0, 4'h0, 1'b0, PH_WB);
        for (int i = 0; i < 20; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            chk_cycle("halt", PH_HALT, 4'hF, 4'h0);
        end

        // Reset while STR is in MEM
        do_reset();
        run_instr(4'h1, 4'h0, 1, 4'b1010, 1'b1, PH_WB);
        run_instr(4'h9, 4'h0, 0, 4'h0, 1'b0, PH_MEM);
        rst_f = 1'b0;
        #1;
        sq_model = 4'b0000;
        chk_cycle("abort_str", PH_RESET, 4'h0, 4'h0);
        step(4'h9, 4'h0, 4'hF, 1'b1);
        chk_cycle("abort_hold", PH_RESET, 4'h0, 4'h0);
        rst_f = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
